// File: rtl/autoscale_bfp.sv
// rtl/autoscale_bfp.sv - multi-channel signed autoscaler with optional block-floating-point frame shift
module autoscale_bfp #(
    parameter int DIN_WIDTH = 16,
    parameter int N_CH      = 2,
    parameter int MAX_SHIFT = 8,
    parameter int MODE      = 0,
    parameter int FRAME_LEN = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [N_CH*DIN_WIDTH-1:0]         din,
    input  logic                              din_valid,
    output logic                              din_ready,
    output logic [N_CH*DIN_WIDTH-1:0]         dout,
    output logic [$clog2(MAX_SHIFT+1)-1:0]    dout_shift,
    output logic                              dout_valid,
    output logic                              dout_last
);
    localparam int SW = $clog2(MAX_SHIFT + 1);
    localparam int AW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int DW = N_CH * DIN_WIDTH;

    typedef enum logic {COLLECT, DRAIN} state_t;

    // Common shift of all channels: min of redundant sign bits, clamped to MAX_SHIFT.
    function automatic logic [SW-1:0] norm_shift(input logic [DW-1:0] v);
        int   best;
        int   c;
        logic done;
        best = MAX_SHIFT;
        for (int k = 0; k < N_CH; k++) begin
            c    = 0;
            done = 1'b0;
            for (int i = DIN_WIDTH - 2; i >= 0; i--) begin
                if (!done && (v[k*DIN_WIDTH+i] == v[k*DIN_WIDTH+DIN_WIDTH-1])) c++;
                else done = 1'b1;
            end
            if (c < best) best = c;
        end
        return best[SW-1:0];
    endfunction

    state_t          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   rd_addr_q, rd_addr_d;
    logic [SW-1:0]   runmin_q, runmin_d;
    logic [SW-1:0]   frame_shift_q, frame_shift_d;
    logic [DW-1:0]   mem_q [FRAME_LEN];
    logic            mem_we;
    logic [DW-1:0]   s1_data_q, s1_data_d;
    logic [SW-1:0]   s1_shift_q, s1_shift_d;
    logic            s1_valid_q, s1_valid_d;
    logic            s1_last_q, s1_last_d;
    logic [DW-1:0]   dout_d;
    logic [SW-1:0]   samp_shift;
    logic [SW-1:0]   samp_min;
    logic            accept;

    assign din_ready  = (MODE == 0) ? 1'b1 : (!rst_n || (state_q == COLLECT));
    assign accept     = din_valid && din_ready;
    assign samp_shift = norm_shift(din);
    assign samp_min   = (samp_shift < runmin_q) ? samp_shift : runmin_q;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        rd_addr_d     = rd_addr_q;
        runmin_d      = runmin_q;
        frame_shift_d = frame_shift_q;
        mem_we        = 1'b0;
        s1_data_d     = s1_data_q;
        s1_shift_d    = s1_shift_q;
        s1_valid_d    = 1'b0;
        s1_last_d     = 1'b0;
        if (MODE == 0) begin
            s1_valid_d = din_valid;
            s1_last_d  = din_valid;
            if (din_valid) begin
                s1_data_d  = din;
                s1_shift_d = samp_shift;
            end
        end else begin
            case (state_q)
                COLLECT: begin
                    if (accept) begin
                        mem_we = 1'b1;
                        if (cnt_q == AW'(FRAME_LEN - 1)) begin
                            frame_shift_d = samp_min;
                            cnt_d         = '0;
                            runmin_d      = SW'(MAX_SHIFT);
                            rd_addr_d     = '0;
                            state_d       = DRAIN;
                        end else begin
                            cnt_d    = cnt_q + AW'(1);
                            runmin_d = samp_min;
                        end
                    end
                end
                DRAIN: begin
                    // Read data carries its own shift so a following frame cannot disturb it.
                    s1_valid_d = 1'b1;
                    s1_data_d  = mem_q[rd_addr_q];
                    s1_shift_d = frame_shift_q;
                    s1_last_d  = (rd_addr_q == AW'(FRAME_LEN - 1));
                    if (rd_addr_q == AW'(FRAME_LEN - 1)) begin
                        rd_addr_d = '0;
                        state_d   = COLLECT;
                    end else begin
                        rd_addr_d = rd_addr_q + AW'(1);
                    end
                end
                default: state_d = COLLECT;
            endcase
        end
    end

    always_comb begin
        dout_d = '0;
        for (int k = 0; k < N_CH; k++) begin
            dout_d[k*DIN_WIDTH +: DIN_WIDTH] = s1_data_q[k*DIN_WIDTH +: DIN_WIDTH] << s1_shift_q;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem_q[cnt_q] <= din;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= COLLECT;
            cnt_q         <= '0;
            rd_addr_q     <= '0;
            runmin_q      <= SW'(MAX_SHIFT);
            frame_shift_q <= '0;
            s1_data_q     <= '0;
            s1_shift_q    <= '0;
            s1_valid_q    <= 1'b0;
            s1_last_q     <= 1'b0;
            dout          <= '0;
            dout_shift    <= '0;
            dout_valid    <= 1'b0;
            dout_last     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rd_addr_q     <= rd_addr_d;
            runmin_q      <= runmin_d;
            frame_shift_q <= frame_shift_d;
            s1_data_q     <= s1_data_d;
            s1_shift_q    <= s1_shift_d;
            s1_valid_q    <= s1_valid_d;
            s1_last_q     <= s1_last_d;
            dout          <= dout_d;
            dout_shift    <= s1_shift_q;
            dout_valid    <= s1_valid_q;
            dout_last     <= s1_last_q;
        end
    end
endmodule

// File: tb/tb_autoscale_bfp.sv
// tb/tb_autoscale_bfp.sv - directed bench for autoscale_bfp in per-sample and frame modes
module tb_autoscale_bfp;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] d0_din, d1_din;
    logic        d0_valid, d1_valid;
    logic        d0_ready, d1_ready;
    logic [31:0] d0_dout, d1_dout;
    logic [3:0]  d0_shift, d1_shift;
    logic        d0_dvalid, d1_dvalid;
    logic        d0_last, d1_last;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    autoscale_bfp #(.DIN_WIDTH(16), .N_CH(2), .MAX_SHIFT(8), .MODE(0), .FRAME_LEN(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .din(d0_din), .din_valid(d0_valid), .din_ready(d0_ready),
        .dout(d0_dout), .dout_shift(d0_shift), .dout_valid(d0_dvalid), .dout_last(d0_last));

    autoscale_bfp #(.DIN_WIDTH(16), .N_CH(2), .MAX_SHIFT(8), .MODE(1), .FRAME_LEN(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .din(d1_din), .din_valid(d1_valid), .din_ready(d1_ready),
        .dout(d1_dout), .dout_shift(d1_shift), .dout_valid(d1_dvalid), .dout_last(d1_last));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  shift;
        logic        last;
        int          cyc;
    } out_t;

    out_t q[$];
    always @(negedge clk) begin
        if (d1_dvalid) q.push_back('{d1_dout, d1_shift, d1_last, cyc});
    end

    typedef struct {
        logic [15:0] c0;
        logic [15:0] c1;
        logic        v;
        logic [15:0] e0;
        logic [15:0] e1;
        logic [3:0]  sh;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic send_frame(input logic [15:0] s[4]);
        for (int i = 0; i < 4; i++) begin
            d1_din   = {16'h0000, s[i]};
            d1_valid = 1'b1;
            step();
        end
        d1_valid = 1'b0;
    endtask

    task automatic check_frame(input string nm, input int base, input logic [15:0] e[4],
                               input logic [3:0] sh);
        if (q.size() >= base + 4) begin
            for (int i = 0; i < 4; i++) begin
                check({nm, "_data"}, q[base+i].data, {16'h0000, e[i]});
                check({nm, "_shift"}, q[base+i].shift, sh);
                check({nm, "_last"}, q[base+i].last, (i == 3));
                if (i > 0) check({nm, "_consecutive"}, q[base+i].cyc - q[base+i-1].cyc, 1);
            end
        end
    endtask

    initial begin
        logic [15:0] fa[4], fb[4], ea[4], eb[4];
        logic [15:0] s4[8];
        int idx, t;

        vecs[0] = '{16'h0100, 16'h0003, 1'b1, 16'h4000, 16'h00C0, 4'd6};
        vecs[1] = '{16'h0010, 16'hFFF0, 1'b1, 16'h1000, 16'hF000, 4'd8};
        vecs[2] = '{16'h8000, 16'h0000, 1'b1, 16'h8000, 16'h0000, 4'd0};
        vecs[3] = '{16'h1234, 16'h0000, 1'b0, 16'h0000, 16'h0000, 4'd0};
        vecs[4] = '{16'h7FFF, 16'h0001, 1'b1, 16'h7FFF, 16'h0001, 4'd0};
        vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFF00, 16'hFF00, 4'd8};
        vecs[6] = '{16'h0400, 16'hFE00, 1'b1, 16'h4000, 16'hE000, 4'd4};
        vecs[7] = '{16'hC000, 16'h0000, 1'b1, 16'h8000, 16'h0000, 4'd1};

        rst_n    = 1'b0;
        d0_din   = '0;
        d1_din   = '0;
        d0_valid = 1'b0;
        d1_valid = 1'b0;
        idle(2);
        check("rst_ready0", d0_ready, 1'b1);
        check("rst_ready1", d1_ready, 1'b1);
        check("rst_outputs0", {d0_dout, d0_shift, d0_dvalid, d0_last}, 0);
        check("rst_outputs1", {d1_dout, d1_shift, d1_dvalid, d1_last}, 0);
        rst_n = 1'b1;
        idle(2);

        // Per-sample mode: vector j is checked two edges after it is driven.
        for (int j = 0; j <= 8; j++) begin
            if (j < 8) begin
                d0_din   = {vecs[j].c1, vecs[j].c0};
                d0_valid = vecs[j].v;
            end else begin
                d0_valid = 1'b0;
            end
            step();
            check("m0_ready", d0_ready, 1'b1);
            if (j >= 1) begin
                check($sformatf("m0_valid_%0d", j-1), d0_dvalid, vecs[j-1].v);
                if (vecs[j-1].v) begin
                    check($sformatf("m0_dout_%0d", j-1), d0_dout, {vecs[j-1].e1, vecs[j-1].e0});
                    check($sformatf("m0_shift_%0d", j-1), d0_shift, vecs[j-1].sh);
                    check($sformatf("m0_last_%0d", j-1), d0_last, 1'b1);
                end
            end
        end
        idle(2);
        check("m0_idle_valid", d0_dvalid, 1'b0);

        // Frame mode: basic frame and din_ready window.
        q.delete();
        fa = '{16'h0004, 16'h0020, 16'hFF00, 16'h0001};
        for (int i = 0; i < 4; i++) begin
            d1_din   = {16'h0000, fa[i]};
            d1_valid = 1'b1;
            step();
        end
        d1_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t3_ready_low_%0d", i), d1_ready, 1'b0);
            step();
        end
        check("t3_ready_back", d1_ready, 1'b1);
        idle(6);
        check("t3_count", q.size(), 4);
        ea = '{16'h0200, 16'h1000, 16'h8000, 16'h0080};
        check_frame("t3", 0, ea, 4'd7);

        // Frame mode: samples offered during drain must be ignored.
        q.delete();
        s4  = '{16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0002, 16'h0004, 16'h0008, 16'h0010};
        idx = 0;
        t   = 0;
        while (idx < 8 && t < 40) begin
            if (d1_ready) begin
                d1_din = {16'h0000, s4[idx]};
                idx++;
            end else begin
                d1_din = {16'h0000, 16'h8000};
            end
            d1_valid = 1'b1;
            step();
            t++;
        end
        d1_valid = 1'b0;
        check("t4_stim_bound", idx, 8);
        idle(10);
        check("t4_count", q.size(), 8);
        ea = '{16'h4000, 16'h4000, 16'h4000, 16'h4000};
        eb = '{16'h0200, 16'h0400, 16'h0800, 16'h1000};
        check_frame("t4a", 0, ea, 4'd6);
        check_frame("t4b", 4, eb, 4'd8);

        // Frame mode: all-zero frame clamps to MAX_SHIFT.
        q.delete();
        fb = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
        send_frame(fb);
        idle(10);
        check("t5_count", q.size(), 4);
        check_frame("t5", 0, fb, 4'd8);

        // Frame mode: reset mid-frame discards the partial frame.
        q.delete();
        for (int i = 0; i < 2; i++) begin
            d1_din   = {16'h0000, 16'h4000};
            d1_valid = 1'b1;
            step();
        end
        d1_valid = 1'b0;
        rst_n    = 1'b0;
        step();
        check("t6_rst_ready", d1_ready, 1'b1);
        check("t6_rst_valid", d1_dvalid, 1'b0);
        rst_n = 1'b1;
        idle(2);
        fa = '{16'h0100, 16'h0100, 16'h0100, 16'h0100};
        send_frame(fa);
        idle(10);
        check("t6_count", q.size(), 4);
        ea = '{16'h4000, 16'h4000, 16'h4000, 16'h4000};
        check_frame("t6", 0, ea, 4'd6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
